// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO input path: parameter floors and the default pin count.
package gpio_pkg;

  localparam int unsigned GpioSyncStagesMin     = 2;
  localparam int unsigned GpioNumGpiosDefault   = 32;
  localparam int unsigned GpioDebounceCyclesMin = 2;
  localparam int unsigned GpioDebounceTicksMin  = 1;

  // Counter width able to hold values 0..max_val.
  function automatic int unsigned gpio_cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Reset-to-zero flop pipeline used at clock-domain crossing points.
module sync_chain #(
  parameter int unsigned Width  = 1,
  parameter int unsigned Stages = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] r_stage [Stages];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Stages; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= d_i;
      for (int i = 1; i < Stages; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign q_o = r_stage[Stages-1];

endmodule

// File: rtl/gpio_input_conditioner.sv
// Pad input conditioning: synchronise, optionally debounce, detect edges, sticky events + irq.
// Debounce is built only when GPIO_INPUT_DEBOUNCE_EN is defined.
module gpio_input_conditioner
  import gpio_pkg::*;
#(
  parameter int unsigned NumGpios       = GpioNumGpiosDefault,
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned DebounceCycles = 1024,
  parameter int unsigned DebounceTicks  = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumGpios-1:0] gpio_async_i,
  output logic [NumGpios-1:0] gpio_o,
  output logic [NumGpios-1:0] rise_o,
  output logic [NumGpios-1:0] fall_o,
  input  logic [NumGpios-1:0] rise_en_i,
  input  logic [NumGpios-1:0] fall_en_i,
  input  logic [NumGpios-1:0] evt_clr_i,
  output logic [NumGpios-1:0] evt_o,
  output logic                irq_o
);

  if (SyncStages < GpioSyncStagesMin) begin : g_err_sync
    $error("SyncStages must be >= 2");
  end
  if (DebounceTicks < GpioDebounceTicksMin) begin : g_err_ticks
    $error("DebounceTicks must be >= 1");
  end
  if (DebounceCycles < GpioDebounceCyclesMin) begin : g_err_cycles
    $error("DebounceCycles must be >= 2");
  end

  localparam int unsigned PrimeW = gpio_cnt_width(SyncStages);

  logic [NumGpios-1:0] w_sync;
  logic [NumGpios-1:0] w_gpio_d;
  logic [NumGpios-1:0] r_gpio, r_rise, r_fall, r_evt;
  logic                r_irq;
  logic [PrimeW-1:0]   r_prime_cnt;
  logic                r_primed;

  sync_chain #(
    .Width  (NumGpios),
    .Stages (SyncStages)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (gpio_async_i),
    .q_o    (w_sync)
  );

  // Hold off edge detection until the synchroniser has flushed its reset zeros.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prime_cnt <= '0;
      r_primed    <= 1'b0;
    end else if (!r_primed) begin
      if (r_prime_cnt == PrimeW'(SyncStages)) r_primed <= 1'b1;
      else                                    r_prime_cnt <= r_prime_cnt + 1'b1;
    end
  end

`ifdef GPIO_INPUT_DEBOUNCE_EN
  localparam int unsigned PrescW = gpio_cnt_width(DebounceCycles - 1);
  localparam int unsigned CntW   = gpio_cnt_width(DebounceTicks);

  logic [PrescW-1:0] r_presc;
  logic              w_tick;
  logic [CntW-1:0]   r_db_cnt [NumGpios];
  logic [CntW-1:0]   w_db_cnt_d [NumGpios];

  assign w_tick = (r_presc == PrescW'(DebounceCycles - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_presc <= '0;
      for (int i = 0; i < NumGpios; i++) r_db_cnt[i] <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      for (int i = 0; i < NumGpios; i++) r_db_cnt[i] <= w_db_cnt_d[i];
    end
  end

  always_comb begin
    w_gpio_d = r_gpio;
    for (int i = 0; i < NumGpios; i++) w_db_cnt_d[i] = r_db_cnt[i];
    if (!r_primed) begin
      w_gpio_d = w_sync;
      for (int i = 0; i < NumGpios; i++) w_db_cnt_d[i] = '0;
    end else begin
      for (int i = 0; i < NumGpios; i++) begin
        if (w_sync[i] == r_gpio[i]) begin
          w_db_cnt_d[i] = '0;
        end else if (w_tick) begin
          if (r_db_cnt[i] == CntW'(DebounceTicks - 1)) begin
            w_gpio_d[i]   = w_sync[i];
            w_db_cnt_d[i] = '0;
          end else begin
            w_db_cnt_d[i] = r_db_cnt[i] + 1'b1;
          end
        end
      end
    end
  end
`else
  assign w_gpio_d = w_sync;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_gpio <= '0;
      r_rise <= '0;
      r_fall <= '0;
      r_evt  <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_gpio <= w_gpio_d;
      r_rise <= {NumGpios{r_primed}} & ~r_gpio & w_gpio_d;
      r_fall <= {NumGpios{r_primed}} & r_gpio & ~w_gpio_d;
      // A set arriving with a clear wins, so no event is lost.
      r_evt  <= (r_evt & ~evt_clr_i) | (r_rise & rise_en_i) | (r_fall & fall_en_i);
      r_irq  <= |r_evt;
    end
  end

  assign gpio_o = r_gpio;
  assign rise_o = r_rise;
  assign fall_o = r_fall;
  assign evt_o  = r_evt;
  assign irq_o  = r_irq;

endmodule
